arbitro_rr: RTL and testbench
=============================

# arbitro_rr

Parametrised round-robin arbiter for the transaction layer. It moves words from NUM_CHANNELS first-word-fall-through input FIFOs to NUM_CHANNELS output FIFOs, routing each word by the destination field in its upper bits. It replaces the fixed 4-channel arbiter with fair rotation and a selectable back-pressure mode. It sits between the FIFO-in bank and the FIFO-out bank, and is gated by the transaction FSM.

## Interface
- NUM_CHANNELS, 4: number of input and output FIFOs; must be a power of 2, at least 2.
- WORD_SIZE, 10: FIFO word width, destination field included.
- DEST_BITS, $clog2(NUM_CHANNELS): destination field width, located at word[WORD_SIZE-1 -: DEST_BITS].
- STALL_MODE, 0: 0 = global stall (any output almost-full blocks all pops); 1 = per-destination stall.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- enable  in  1  arbitration allowed; driven by the FSM ACTIVE state.
- fifo_in_empty  in  NUM_CHANNELS  empty flags of the input FIFOs.
- fifo_in_data  in  NUM_CHANNELS*WORD_SIZE  head words; channel i at [i*WORD_SIZE +: WORD_SIZE].
- fifo_out_almost_full  in  NUM_CHANNELS  almost-full flags of the output FIFOs.
- pop_in  out  NUM_CHANNELS  one-hot (or zero) pop to the input FIFOs; combinational.
- push_out  out  NUM_CHANNELS  one-hot (or zero) push to the output FIFOs; registered.
- data_out  out  WORD_SIZE  word shared by all output FIFOs; registered.
- busy  out  1  high while any request is pending or a push is in flight.

## Operation
- Destination of channel i: dest_i = head word bits [WORD_SIZE-1 -: DEST_BITS].
- Request: req[i] = enable & ~fifo_in_empty[i] & eligible[i].
- Eligibility:
  - STALL_MODE 0: eligible[i] = ~|fifo_out_almost_full.
  - STALL_MODE 1: eligible[i] = ~fifo_out_almost_full[dest_i].
- Grant selection: search upward from rr_ptr, modulo NUM_CHANNELS; the first req[i] set wins. At most one grant per cycle.
- pop_in[g] = 1 for the granted channel only.
- rr_ptr update:
  - On a grant, rr_ptr <= (g+1) mod NUM_CHANNELS, wrapping at NUM_CHANNELS-1 to 0.
  - With no grant, rr_ptr holds.
- Registered stage:
  - On a grant: data_out <= head word of g, and push_out <= one-hot(dest_g).
  - With no grant: push_out <= 0 and data_out holds its last value.
- busy = |req | |push_out.
- The word is consumed and the destination field is forwarded unchanged in data_out.

## Timing
- Reset values (asynchronous, while reset_L = 0): push_out = 0, data_out = 0, rr_ptr = 0. pop_in and busy are forced to 0 while reset_L is low.
- Latency: the word popped in cycle t is pushed to its output FIFO in cycle t+1, visible after the edge ending cycle t. Throughput is 1 word per cycle.
- Back-pressure skid: an almost-full flag that rises in cycle t stops pops in cycle t. One push from cycle t-1 may still land, so each output FIFO's almost-full threshold must leave at least 1 free slot.
- enable falling in cycle t: no pop in cycle t. A push already registered from t-1 still completes.
- Reset mid-transfer: an in-flight push is dropped. The input word was already popped, so this loss is accepted by design.
- Simultaneous requests on all channels rotate strictly: grants go to ptr, ptr+1, and so on.
- Several inputs targeting the same destination are serialised by the single grant.
- Empty and almost-full flags are sampled in the same cycle as the grant; there is no internal holding register.

## Structure
- Shared package arbitro_pkg holds:
  - STALL_GLOBAL = 0 and STALL_PER_DEST = 1 constants.
  - Function dest_of(word) returning the destination field.
- One sub-module, rr_pick: a combinational round-robin priority encoder.
  - Inputs: req[N-1:0] and ptr.
  - Outputs: grant one-hot, grant_idx, any.
  - It is reused by future multi-port arbiters.
- The top level holds rr_ptr and the output register. There is no other state.

## Test plan
- Reset: assert reset_L = 0 mid-stream with push_out active → push_out = 0, data_out = 0, rr_ptr = 0 asynchronously. The first grant after release goes to channel 0.
- Rotation: N = 4, all inputs non-empty, 3 words each (10'h0A6, 10'h145, 10'h278, 10'h389) → pops in order ch0, ch1, ch2, ch3, ch0, …; pushes on out0, out1, out2, out3 one cycle later; 12 pushes total; busy falls 1 cycle after the last push.
- Wrap: only ch3 and ch0 requesting, rr_ptr = 3 → grant ch3, then ch0, then ch3.
- Global stall (STALL_MODE 0): raise fifo_out_almost_full[0] while ch1 holds 10'h145 → no pop_in on any channel until the flag drops; the pop resumes in the same cycle the flag drops.
- Per-destination stall (STALL_MODE 1): fifo_out_almost_full[0] = 1; ch0 head 10'h0A6, ch1 head 10'h145 → ch1 is popped every cycle and ch0 waits. Clearing the flag grants ch0 at its next turn.
- Enable gating: enable = 0 with all FIFOs non-empty → pop_in = 0 and push_out = 0 for 10 cycles. Setting enable = 1 grants the channel at rr_ptr in the same cycle.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared definitions for the round-robin arbiter: stall-mode selectors and
// the helper that extracts the destination field from a FIFO word.
package arbitro_pkg;

  localparam int STALL_GLOBAL   = 0;
  localparam int STALL_PER_DEST = 1;

  // Widest word the helper accepts; callers zero-extend into this width.
  localparam int MAX_WORD_SIZE = 64;

  // Destination field sits in the top dest_bits bits of a word_size-bit word.
  function automatic logic [31:0] dest_of(input logic [MAX_WORD_SIZE-1:0] word,
                                          input int word_size,
                                          input int dest_bits);
    logic [MAX_WORD_SIZE-1:0] shifted;
    logic [31:0]              mask;
    shifted = word >> (word_size - dest_bits);
    mask    = (32'd1 << dest_bits) - 32'd1;
    return shifted[31:0] & mask;
  endfunction

endpackage

// File: rtl/arbitro_rr_pick.sv
// Combinational round-robin priority encoder: the first asserted request at
// or above ptr (wrapping modulo N) wins. N must be a power of two so the
// index addition wraps naturally.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  logic [PW-1:0] idx;

  // Walk the requests starting at ptr and latch onto the first one found.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + PW'(k);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter moving words from NUM_CHANNELS FWFT input FIFOs to
// NUM_CHANNELS output FIFOs, routed by the destination field in each word.
// Pops are combinational; the push and its data are registered one cycle later.
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int WORD_SIZE    = 10,
  parameter int DEST_BITS    = $clog2(NUM_CHANNELS),
  parameter int STALL_MODE   = STALL_GLOBAL
) (
  input  logic                              clk,
  input  logic                              reset_L,
  input  logic                              enable,
  input  logic [NUM_CHANNELS-1:0]           fifo_in_empty,
  input  logic [NUM_CHANNELS*WORD_SIZE-1:0] fifo_in_data,
  input  logic [NUM_CHANNELS-1:0]           fifo_out_almost_full,
  output logic [NUM_CHANNELS-1:0]           pop_in,
  output logic [NUM_CHANNELS-1:0]           push_out,
  output logic [WORD_SIZE-1:0]              data_out,
  output logic                              busy
);

  localparam int PW = $clog2(NUM_CHANNELS);

  logic [WORD_SIZE-1:0]    head [NUM_CHANNELS];
  logic [DEST_BITS-1:0]    dest [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] eligible;
  logic [NUM_CHANNELS-1:0] req;
  logic [NUM_CHANNELS-1:0] grant;
  logic [NUM_CHANNELS-1:0] push_next;
  logic [PW-1:0]           grant_idx;
  logic [PW-1:0]           rr_ptr;
  logic                    any_grant;

  // Split the head words, find each destination and decide who may request.
  always_comb begin
    eligible = '0;
    req      = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      head[i] = fifo_in_data[i*WORD_SIZE +: WORD_SIZE];
      dest[i] = DEST_BITS'(dest_of(MAX_WORD_SIZE'(head[i]), WORD_SIZE, DEST_BITS));
      if (STALL_MODE == STALL_PER_DEST) begin
        eligible[i] = ~fifo_out_almost_full[dest[i]];
      end else begin
        eligible[i] = ~|fifo_out_almost_full;
      end
      req[i] = enable & ~fifo_in_empty[i] & eligible[i];
    end
  end

  rr_pick #(
    .N  (NUM_CHANNELS),
    .PW (PW)
  ) u_pick (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_grant)
  );

  // Pops and busy are silenced while reset is held so nothing is consumed.
  always_comb begin
    pop_in = reset_L ? grant : '0;
    busy   = reset_L & ((|req) | (|push_out));
  end

  // One-hot push target for the word currently being granted.
  always_comb begin
    push_next                  = '0;
    push_next[dest[grant_idx]] = 1'b1;
  end

  // Advance the rotation pointer past the winner; hold it when idle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= grant_idx + PW'(1);
    end
  end

  // Register the popped word and its push strobe; data holds between grants.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      push_out <= '0;
      data_out <= '0;
    end else if (any_grant) begin
      push_out <= push_next;
      data_out <= head[grant_idx];
    end else begin
      push_out <= '0;
    end
  end

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr: one instance in global-stall mode, one in
// per-destination mode, sharing all inputs.
module tb_arbitro_rr;
  import arbitro_pkg::*;

  logic        clk;
  logic        reset_L;
  logic        enable;
  logic [3:0]  fifo_in_empty;
  logic [39:0] fifo_in_data;
  logic [3:0]  fifo_out_almost_full;

  logic [3:0]  pop_g, push_g, pop_p, push_p;
  logic [9:0]  data_g, data_p;
  logic        busy_g, busy_p;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       en;
    logic [3:0] empty;
    logic [3:0] afull;
    logic [3:0] pop;
    logic [3:0] push;
    logic [9:0] data;
    logic       busy;
  } vec_t;

  vec_t vecs_g[$];
  vec_t vecs_p[$];

  arbitro_rr #(
    .NUM_CHANNELS (4),
    .WORD_SIZE    (10),
    .STALL_MODE   (STALL_GLOBAL)
  ) dut_g (
    .clk                  (clk),
    .reset_L              (reset_L),
    .enable               (enable),
    .fifo_in_empty        (fifo_in_empty),
    .fifo_in_data         (fifo_in_data),
    .fifo_out_almost_full (fifo_out_almost_full),
    .pop_in               (pop_g),
    .push_out             (push_g),
    .data_out             (data_g),
    .busy                 (busy_g)
  );

  arbitro_rr #(
    .NUM_CHANNELS (4),
    .WORD_SIZE    (10),
    .STALL_MODE   (STALL_PER_DEST)
  ) dut_p (
    .clk                  (clk),
    .reset_L              (reset_L),
    .enable               (enable),
    .fifo_in_empty        (fifo_in_empty),
    .fifo_in_data         (fifo_in_data),
    .fifo_out_almost_full (fifo_out_almost_full),
    .pop_in               (pop_p),
    .push_out             (push_p),
    .data_out             (data_p),
    .busy                 (busy_p)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic en, input logic [3:0] empty,
                              input logic [3:0] afull, input logic [3:0] pop,
                              input logic [3:0] push, input logic [9:0] data,
                              input logic busy);
    vec_t v;
    v.en = en; v.empty = empty; v.afull = afull;
    v.pop = pop; v.push = push; v.data = data; v.busy = busy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] empty,
                               input logic [3:0] afull);
    enable               = en;
    fifo_in_empty        = empty;
    fifo_out_almost_full = afull;
  endtask

  // Drive one vector just after a rising edge, compare at the falling edge.
  task automatic applyVector(input vec_t v, input bit use_p, input string tag);
    applyStimulus(v.en, v.empty, v.afull);
    @(negedge clk);
    checkOutput({tag, " pop"},  32'(use_p ? pop_p  : pop_g),  32'(v.pop));
    checkOutput({tag, " push"}, 32'(use_p ? push_p : push_g), 32'(v.push));
    checkOutput({tag, " data"}, 32'(use_p ? data_p : data_g), 32'(v.data));
    checkOutput({tag, " busy"}, 32'(use_p ? busy_p : busy_g), 32'(v.busy));
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 4'hF, 4'h0);
    reset_L = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    fifo_in_data = {10'h389, 10'h278, 10'h145, 10'h0A6};
    reset_L      = 1'b0;
    applyStimulus(1'b1, 4'h0, 4'h0);

    // Reset state with requests present: everything quiet.
    @(negedge clk);
    checkOutput("reset push", 32'(push_g), 32'h0);
    checkOutput("reset data", 32'(data_g), 32'h0);
    checkOutput("reset pop",  32'(pop_g),  32'h0);
    checkOutput("reset busy", 32'(busy_g), 32'h0);
    checkOutput("reset pop_p", 32'(pop_p), 32'h0);
    applyStimulus(1'b0, 4'hF, 4'h0);
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;

    // Rotation: three words per channel, then the drain.
    vecs_g.push_back(mk(1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 10'h000, 1));
    vecs_g.push_back(mk(1, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 10'h0A6, 1));
    vecs_g.push_back(mk(1, 4'b0000, 4'b0000, 4'b0100, 4'b0010, 10'h145, 1));
    vecs_g.push_back(mk(1, 4'b0000, 4'b0000, 4'b1000, 4'b0100, 10'h278, 1));
    vecs_g.push_back(mk(1, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 10'h389, 1));
    vecs_g.push_back(mk(1, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 10'h0A6, 1));
    vecs_g.push_back(mk(1, 4'b0000, 4'b0000, 4'b0100, 4'b0010, 10'h145, 1));
    vecs_g.push_back(mk(1, 4'b0000, 4'b0000, 4'b1000, 4'b0100, 10'h278, 1));
    vecs_g.push_back(mk(1, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 10'h389, 1));
    vecs_g.push_back(mk(1, 4'b0001, 4'b0000, 4'b0010, 4'b0001, 10'h0A6, 1));
    vecs_g.push_back(mk(1, 4'b0011, 4'b0000, 4'b0100, 4'b0010, 10'h145, 1));
    vecs_g.push_back(mk(1, 4'b0111, 4'b0000, 4'b1000, 4'b0100, 10'h278, 1));
    vecs_g.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 10'h389, 1));
    vecs_g.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 10'h389, 0));
    // Enable low for 10 cycles with every FIFO holding data.
    for (int i = 0; i < 10; i++)
      vecs_g.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 10'h389, 0));
    // Enable high: the pointer channel (0) is granted at once.
    vecs_g.push_back(mk(1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 10'h389, 1));
    // Walk the pointer up to 3.
    vecs_g.push_back(mk(1, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 10'h0A6, 1));
    vecs_g.push_back(mk(1, 4'b0000, 4'b0000, 4'b0100, 4'b0010, 10'h145, 1));
    // Wrap: only ch3 and ch0 requesting -> ch3, ch0, ch3.
    vecs_g.push_back(mk(1, 4'b0110, 4'b0000, 4'b1000, 4'b0100, 10'h278, 1));
    vecs_g.push_back(mk(1, 4'b0110, 4'b0000, 4'b0001, 4'b1000, 10'h389, 1));
    vecs_g.push_back(mk(1, 4'b0110, 4'b0000, 4'b1000, 4'b0001, 10'h0A6, 1));
    // Global stall: out0 almost full blocks ch1 (dest 1) too.
    vecs_g.push_back(mk(1, 4'b1101, 4'b0001, 4'b0000, 4'b1000, 10'h389, 1));
    vecs_g.push_back(mk(1, 4'b1101, 4'b0001, 4'b0000, 4'b0000, 10'h389, 0));
    vecs_g.push_back(mk(1, 4'b1101, 4'b0001, 4'b0000, 4'b0000, 10'h389, 0));
    vecs_g.push_back(mk(1, 4'b1101, 4'b0000, 4'b0010, 4'b0000, 10'h389, 1));
    vecs_g.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 10'h145, 1));
    vecs_g.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 10'h145, 0));

    foreach (vecs_g[i]) applyVector(vecs_g[i], 1'b0, $sformatf("g%0d", i));

    // Reset mid-stream: pointer sits at 2, one grant moves it to 3.
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("mid pop", 32'(pop_g), 32'b0100);
    @(posedge clk);
    #1;
    checkOutput("mid push", 32'(push_g), 32'b0100);
    checkOutput("mid data", 32'(data_g), 32'h278);
    reset_L = 1'b0;
    #1;
    checkOutput("async push", 32'(push_g), 32'h0);
    checkOutput("async data", 32'(data_g), 32'h0);
    checkOutput("async pop",  32'(pop_g),  32'h0);
    checkOutput("async busy", 32'(busy_g), 32'h0);
    @(negedge clk);
    reset_L = 1'b1;
    #1;
    checkOutput("post-reset pop", 32'(pop_g), 32'b0001);
    @(posedge clk);
    #1;
    checkOutput("post-reset push", 32'(push_g), 32'b0001);
    checkOutput("post-reset data", 32'(data_g), 32'h0A6);

    // Per-destination stall: ch0 (dest 0) waits, ch1 keeps flowing.
    doReset();
    vecs_p.push_back(mk(1, 4'b1100, 4'b0001, 4'b0010, 4'b0000, 10'h000, 1));
    vecs_p.push_back(mk(1, 4'b1100, 4'b0001, 4'b0010, 4'b0010, 10'h145, 1));
    vecs_p.push_back(mk(1, 4'b1100, 4'b0001, 4'b0010, 4'b0010, 10'h145, 1));
    vecs_p.push_back(mk(1, 4'b1100, 4'b0000, 4'b0001, 4'b0010, 10'h145, 1));
    vecs_p.push_back(mk(1, 4'b1100, 4'b0000, 4'b0010, 4'b0001, 10'h0A6, 1));
    vecs_p.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 10'h145, 1));
    vecs_p.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 10'h145, 0));

    foreach (vecs_p[i]) applyVector(vecs_p[i], 1'b1, $sformatf("p%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
